sar_afe_model: RTL and testbench
================================

Name: sar_afe_model

Overview:
- Digital behavioural model of the differential SAR analog front-end: sampling switch, capacitive DAC and dual-output comparator.
- It is the responder to the SAR ADC controller. It consumes the controller's `sample` and `dac_p`/`dac_n` codes and returns `comp_p`/`comp_n` decisions, so the controller can be simulated RTL-only without ngspice.
- It also checks the controller's DAC switching protocol and reports the code the ideal converter should produce, for scoreboarding.

Parameters:
- RESOLUTION, 8, converter resolution in bits (N); must be at least 2.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- ain_i  input  RESOLUTION  "analog" input expressed as the ideal output code H (unsigned)
- sample_i  input  1  sample strobe from the controller
- dac_p_i  input  RESOLUTION  positive CDAC switch code from the controller
- dac_n_i  input  RESOLUTION  negative CDAC switch code from the controller
- comp_p_o  output  1  comparator positive output (vip > vin)
- comp_n_o  output  1  comparator negative output (vip < vin)
- done_o  output  1  one-cycle pulse after the last bit is evaluated
- code_o  output  RESOLUTION  model's own decisions for the last completed conversion
- err_o  output  1  sticky protocol-violation flag
- conv_cnt_o  output  16  completed-conversion counter

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE, held value=0, bit_cnt=0, decision register=0.
  - code_o=0, done_o=0, err_o=0, conv_cnt_o=0.
  - comp_p_o=comp_n_o=0.
- States: IDLE, HOLD.
  - Any state, posedge with sample_i=1: held value <= ain_i, state <= HOLD, bit_cnt <= 0, decision register <= 0.
  - Sampling repeats every cycle sample_i stays high; the last value before sample_i falls is held.
- Evaluation condition: eval = (state==HOLD) && !sample_i.
- Comparator (combinational, same-cycle response to dac_*_i):
  - diff = 2*H + 1 - 2^N - dac_p_i + dac_n_i, signed N+2 bits.
  - diff is always odd, never zero.
  - If eval: comp_p_o = (diff > 0), comp_n_o = (diff < 0).
  - Otherwise both outputs are 0 (comparator reset phase).
- Per eval posedge, with k = bit_cnt and m = 1 << (N-1-k):
  - decision register bit (N-1-k) <= comp_p_o.
  - bit_cnt <= k+1.
  - At k = N-1: code_o <= final decisions, done_o pulses 1 next cycle, conv_cnt_o increments (wraps 0xFFFF to 0), state <= IDLE.
- Protocol checker, evaluated each eval cycle; any failure sets err_o=1, cleared only by reset:
  - (dac_p_i & dac_n_i) must be 0.
  - (dac_p_i | dac_n_i) must equal all bits above m set, m and below clear.
  - dac_p_i must equal decision-register bits above m.
- sample_i=1 while in HOLD mid-conversion: the conversion is aborted.
  - No done_o, code_o unchanged.
  - Restart from the new sample.
  - Not an error.
- IDLE with sample_i=0: outputs idle, no checks.
- Reset mid-conversion: all state returns to reset values on that edge; no done_o.

Optional Feature:
- Macro: SAR_AFE_COMP_NOISE_EN.
- When defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1, advances only on eval cycles.
  - Comparator uses diff + (lfsr[0] ? +2 : -2), so decisions flip only at |diff|==1.
  - The protocol checker still uses the actual decisions.
- When undefined: no LFSR is instantiated and the comparator is fully deterministic.

Test Plan (RESOLUTION=8):
- ain_i=0xA5, 1-cycle sample_i, controller-correct DAC sequence -> comp_p_o per bit 1,0,1,0,0,1,0,1; done_o pulse; code_o=0xA5; conv_cnt_o=1; err_o=0.
- ain_i=0x00 then 0xFF, back-to-back conversions -> comp_p_o all 0 then all 1; code_o=0x00 then 0xFF; conv_cnt_o=2.
- ain_i=0x80 and 0x7F -> first-cycle comp_p_o=1 and 0 respectively; code_o=0x80 and 0x7F.
- Eval cycle 2 with dac_p_i=0xC0, dac_n_i=0x40 (overlapping bit) -> err_o=1, held through later clean conversions until rst_i.
- sample_i reasserted at bit 4, new ain_i=0x3C -> no done_o for the aborted conversion; next done_o gives code_o=0x3C.
- rst_i at bit 5 -> comp outputs 0/0 next cycle, no done_o, conv_cnt_o=0, code_o=0.

Source files
------------

// File: rtl/sar_afe_model.sv
// Behavioural differential SAR front-end: sample/hold, CDAC comparator and DAC-protocol checker.
// Optional comparator noise dither is enabled by defining SAR_AFE_COMP_NOISE_EN.
module sar_afe_model #(
  parameter int RESOLUTION = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [RESOLUTION-1:0] ain_i,
  input  logic                  sample_i,
  input  logic [RESOLUTION-1:0] dac_p_i,
  input  logic [RESOLUTION-1:0] dac_n_i,
  output logic                  comp_p_o,
  output logic                  comp_n_o,
  output logic                  done_o,
  output logic [RESOLUTION-1:0] code_o,
  output logic                  err_o,
  output logic [15:0]           conv_cnt_o
);

  localparam int N  = RESOLUTION;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N+2:0] HALF = {3'b001, {N{1'b0}}};

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_next;
  logic [N-1:0]   held;
  logic [N-1:0]   dec;
  logic [N-1:0]   dec_next;
  logic [N-1:0]   above;
  logic [N-1:0]   code_q;
  logic [CW-1:0]  bit_cnt;
  logic           last;
  logic           eval;
  logic           proto_bad;
  logic           done_q;
  logic           err_q;
  logic [15:0]    cnt_q;
  logic [N+2:0]   diff_u;
  logic signed [N+2:0] diff;

`ifdef SAR_AFE_COMP_NOISE_EN
  localparam logic [N+2:0] PLUS2  = {{(N+1){1'b0}}, 2'b10};
  localparam logic [N+2:0] MINUS2 = {{(N+1){1'b1}}, 2'b10};
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      lfsr <= 16'hACE1;
    else if (eval)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  // Differential input minus CDAC: 2H+1-2^N-p+n, one guard bit wider so dither cannot overflow.
  always_comb begin
    diff_u = {2'b00, held, 1'b1} - HALF - {3'b000, dac_p_i} + {3'b000, dac_n_i};
`ifdef SAR_AFE_COMP_NOISE_EN
    diff_u = diff_u + (lfsr[0] ? PLUS2 : MINUS2);
`endif
  end

  assign diff = $signed(diff_u);
  assign last = (bit_cnt == CW'(N - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (sample_i)
      state_next = HOLD;
    else if (eval && last)
      state_next = IDLE;
  end

  // Comparator is held in its reset phase (both outputs low) unless evaluating.
  always_comb begin
    eval     = (state == HOLD) && !sample_i;
    comp_p_o = eval && (diff > 0);
    comp_n_o = eval && (diff < 0);
  end

  // Bits already resolved by the controller; the bit under test and below must be released.
  always_comb begin
    above    = '0;
    dec_next = dec;
    for (int i = 0; i < N; i++) begin
      if ((i + int'(bit_cnt)) >= N)
        above[i] = 1'b1;
      if (eval && (i == (N - 1 - int'(bit_cnt))))
        dec_next[i] = comp_p_o;
    end
  end

  assign proto_bad = ((dac_p_i & dac_n_i) != '0) ||
                     ((dac_p_i | dac_n_i) != above) ||
                     (dac_p_i != (dec & above));

  // A new sample always wins, which also covers aborting a conversion mid-way.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held    <= '0;
      bit_cnt <= '0;
      dec     <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (sample_i) begin
        held    <= ain_i;
        bit_cnt <= '0;
        dec     <= '0;
      end else if (eval) begin
        dec     <= dec_next;
        bit_cnt <= bit_cnt + 1'b1;
        if (proto_bad)
          err_q <= 1'b1;
        if (last) begin
          code_q <= dec_next;
          done_q <= 1'b1;
          cnt_q  <= cnt_q + 16'd1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign code_o     = code_q;
  assign err_o      = err_q;
  assign conv_cnt_o = cnt_q;

endmodule

// File: tb/tb_sar_afe_model.sv
// Self-checking bench for sar_afe_model: an ideal SAR controller drives the CDAC,
// and expectations come from the ideal binary search on the held input code.
module tb_sar_afe_model;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [N-1:0] ain_i = '0;
  logic         sample_i = 1'b0;
  logic [N-1:0] dac_p_i = '0;
  logic [N-1:0] dac_n_i = '0;
  logic         comp_p_o;
  logic         comp_n_o;
  logic         done_o;
  logic [N-1:0] code_o;
  logic         err_o;
  logic [15:0]  conv_cnt_o;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [N-1:0] exp_code = '0;

  sar_afe_model #(.RESOLUTION(N)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ain_i      (ain_i),
    .sample_i   (sample_i),
    .dac_p_i    (dac_p_i),
    .dac_n_i    (dac_n_i),
    .comp_p_o   (comp_p_o),
    .comp_n_o   (comp_n_o),
    .done_o     (done_o),
    .code_o     (code_o),
    .err_o      (err_o),
    .conv_cnt_o (conv_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // One-cycle sample strobe; leaves the bench just after the capturing edge.
  task automatic do_sample(input logic [N-1:0] h);
    sample_i = 1'b1;
    ain_i    = h;
    dac_p_i  = '0;
    dac_n_i  = '0;
    @(posedge clk_i); #1;
    sample_i = 1'b0;
  endtask

  // Ideal controller: bit k tests prefix+m; bad_mode 1 overlaps p/n, 2 flips a resolved p bit.
  task automatic drive_bits(input logic [N-1:0] h, input int nbits, input int bad_k,
                            input int bad_mode, output logic [N-1:0] obs_p,
                            output logic [N-1:0] obs_n);
    int prefix, m, above, p, n;
    obs_p  = '0;
    obs_n  = '0;
    prefix = 0;
    for (int k = 0; k < nbits; k++) begin
      m     = 1 << (N - 1 - k);
      above = (1 << N) - 2 * m;
      p     = prefix;
      n     = above - prefix;
      if (k == bad_k && bad_mode == 1) begin
        p = above;
        n = m << 1;
      end else if (k == bad_k && bad_mode == 2) begin
        p = prefix ^ (1 << (N - 1));
        n = above & ~p;
      end
      dac_p_i = N'(p);
      dac_n_i = N'(n);
      @(negedge clk_i);
      obs_p[N-1-k] = comp_p_o;
      obs_n[N-1-k] = comp_n_o;
      @(posedge clk_i); #1;
      if (int'(h) >= prefix + m)
        prefix += m;
    end
    dac_p_i = '0;
    dac_n_i = '0;
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    sample_i = 1'b1;
    ain_i    = N'($urandom);
    dac_p_i  = N'($urandom);
    dac_n_i  = N'($urandom);
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
    checks++; if (code_o !== '0) begin errors++; $display("[TB] FAIL reset_code got %h want 00", code_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err_o); end
    checks++; if (conv_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", conv_cnt_o); end
    checks++; if ({comp_p_o, comp_n_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_comp got %b%b want 00", comp_p_o, comp_n_o); end
    rst_i    = 1'b0;
    sample_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({comp_p_o, comp_n_o} !== 2'b00) begin errors++; $display("[TB] FAIL idle_comp got %b%b want 00", comp_p_o, comp_n_o); end
    @(posedge clk_i); #1;
    dac_p_i  = '0;
    dac_n_i  = '0;
    exp_cnt  = '0;
    exp_code = '0;
  endtask

  task automatic test_known_a5();
    logic [N-1:0] op, on;
    do_sample(8'hA5);
    drive_bits(8'hA5, N, -1, 0, op, on);
    exp_cnt++;
    exp_code = 8'hA5;
    checks++; if (op !== 8'hA5) begin errors++; $display("[TB] FAIL a5_comp_p got %h want a5", op); end
    checks++; if (on !== 8'h5A) begin errors++; $display("[TB] FAIL a5_comp_n got %h want 5a", on); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL a5_done got %b want 1", done_o); end
    checks++; if (code_o !== 8'hA5) begin errors++; $display("[TB] FAIL a5_code got %h want a5", code_o); end
    checks++; if (conv_cnt_o !== exp_cnt) begin errors++; $display("[TB] FAIL a5_cnt got %0d want %0d", conv_cnt_o, exp_cnt); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL a5_err got %b want 0", err_o); end
    @(posedge clk_i); #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL a5_done_pulse got %b want 0", done_o); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] op, on;
    logic [N-1:0] vals [2];
    vals[0] = 8'h00;
    vals[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      do_sample(vals[i]);
      drive_bits(vals[i], N, -1, 0, op, on);
      exp_cnt++;
      exp_code = vals[i];
      checks++; if (op !== vals[i]) begin errors++; $display("[TB] FAIL b2b_comp_p got %h want %h", op, vals[i]); end
      checks++; if (code_o !== vals[i]) begin errors++; $display("[TB] FAIL b2b_code got %h want %h", code_o, vals[i]); end
      checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got %b want 1", done_o); end
      checks++; if (conv_cnt_o !== exp_cnt) begin errors++; $display("[TB] FAIL b2b_cnt got %0d want %0d", conv_cnt_o, exp_cnt); end
    end
  endtask

  task automatic test_midscale();
    logic [N-1:0] op, on;
    logic [N-1:0] vals [2];
    vals[0] = 8'h80;
    vals[1] = 8'h7F;
    for (int i = 0; i < 2; i++) begin
      do_sample(vals[i]);
      drive_bits(vals[i], N, -1, 0, op, on);
      exp_cnt++;
      exp_code = vals[i];
      checks++; if (op[N-1] !== vals[i][N-1]) begin errors++; $display("[TB] FAIL mid_first_bit got %b want %b", op[N-1], vals[i][N-1]); end
      checks++; if (code_o !== vals[i]) begin errors++; $display("[TB] FAIL mid_code got %h want %h", code_o, vals[i]); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] op, on, h;
    int gap, len;
    h = '0;
    repeat (24) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk_i); #1;
      end
      len = $urandom_range(1, 3);
      sample_i = 1'b1;
      for (int i = 0; i < len; i++) begin
        h     = N'($urandom);
        ain_i = h;
        @(posedge clk_i); #1;
      end
      sample_i = 1'b0;
      drive_bits(h, N, -1, 0, op, on);
      exp_cnt++;
      exp_code = h;
      checks++; if (op !== h) begin errors++; $display("[TB] FAIL rnd_comp_p got %h want %h", op, h); end
      checks++; if (on !== ~h) begin errors++; $display("[TB] FAIL rnd_comp_n got %h want %h", on, ~h); end
      checks++; if (code_o !== h) begin errors++; $display("[TB] FAIL rnd_code got %h want %h", code_o, h); end
      checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL rnd_done got %b want 1", done_o); end
      checks++; if (conv_cnt_o !== exp_cnt) begin errors++; $display("[TB] FAIL rnd_cnt got %0d want %0d", conv_cnt_o, exp_cnt); end
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err got %b want 0", err_o); end
  endtask

  task automatic test_abort();
    logic [N-1:0] op, on, h;
    h = N'($urandom);
    do_sample(h);
    drive_bits(h, 4, -1, 0, op, on);
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_early_done got %b want 0", done_o); end
    sample_i = 1'b1;
    ain_i    = 8'h3C;
    @(negedge clk_i);
    checks++; if ({comp_p_o, comp_n_o} !== 2'b00) begin errors++; $display("[TB] FAIL abort_comp got %b%b want 00", comp_p_o, comp_n_o); end
    @(posedge clk_i); #1;
    sample_i = 1'b0;
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", done_o); end
    checks++; if (code_o !== exp_code) begin errors++; $display("[TB] FAIL abort_code_kept got %h want %h", code_o, exp_code); end
    drive_bits(8'h3C, N, -1, 0, op, on);
    exp_cnt++;
    exp_code = 8'h3C;
    checks++; if (code_o !== 8'h3C) begin errors++; $display("[TB] FAIL abort_code got %h want 3c", code_o); end
    checks++; if (conv_cnt_o !== exp_cnt) begin errors++; $display("[TB] FAIL abort_cnt got %0d want %0d", conv_cnt_o, exp_cnt); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_err got %b want 0", err_o); end
  endtask

  task automatic test_protocol_err();
    logic [N-1:0] op, on, h;
    h = N'($urandom);
    do_sample(h);
    drive_bits(h, N, 2, 1, op, on);
    exp_cnt++;
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL overlap_err got %b want 1", err_o); end
    checks++; if (conv_cnt_o !== exp_cnt) begin errors++; $display("[TB] FAIL overlap_cnt got %0d want %0d", conv_cnt_o, exp_cnt); end
    h = N'($urandom);
    do_sample(h);
    drive_bits(h, N, -1, 0, op, on);
    exp_cnt++;
    exp_code = h;
    checks++; if (code_o !== h) begin errors++; $display("[TB] FAIL sticky_code got %h want %h", code_o, h); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL sticky_err got %b want 1", err_o); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] op, on, h;
    h = N'($urandom);
    do_sample(h);
    drive_bits(h, 5, -1, 0, op, on);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_cnt  = '0;
    exp_code = '0;
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done got %b want 0", done_o); end
    checks++; if (conv_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_cnt got %0d want 0", conv_cnt_o); end
    checks++; if (code_o !== '0) begin errors++; $display("[TB] FAIL rstmid_code got %h want 00", code_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_err got %b want 0", err_o); end
    dac_p_i = 8'h80;
    @(negedge clk_i);
    checks++; if ({comp_p_o, comp_n_o} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_comp got %b%b want 00", comp_p_o, comp_n_o); end
    @(posedge clk_i); #1;
    dac_p_i = '0;
    h = N'($urandom);
    do_sample(h);
    drive_bits(h, N, -1, 0, op, on);
    exp_cnt++;
    checks++; if (conv_cnt_o !== exp_cnt) begin errors++; $display("[TB] FAIL rstmid_next_cnt got %0d want %0d", conv_cnt_o, exp_cnt); end
    checks++; if (code_o !== h) begin errors++; $display("[TB] FAIL rstmid_next_code got %h want %h", code_o, h); end
  endtask

  task automatic test_wrong_prefix();
    logic [N-1:0] op, on, h;
    h = N'($urandom);
    do_sample(h);
    drive_bits(h, N, 3, 2, op, on);
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL prefix_err got %b want 1", err_o); end
  endtask

  initial begin
    test_reset();
    test_known_a5();
    test_back_to_back();
    test_midscale();
    test_random();
    test_abort();
    test_protocol_err();
    test_reset_mid();
    test_wrong_prefix();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
